// File: rtl/core_pkg.sv
// Shared core types for the pipeline hazard sequencer: FSM state encoding,
// perf counter selects and the stall/bubble/flush control bundle.
package core;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MDU_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2
    } hazard_state_t;

    localparam logic [1:0] PERF_SEL_LU  = 2'd0;
    localparam logic [1:0] PERF_SEL_MDU = 2'd1;
    localparam logic [1:0] PERF_SEL_FL  = 2'd2;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic bubble_ex;
        logic flush_if_id;
    } hazard_cntrl_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating event counters for hazard stalls; only instantiated when the
// HAZARD_PERF_CNT_EN build option is defined.
module hazard_perf_counters
    import core::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lu_evt,
    input  logic        mdu_evt,
    input  logic        fl_evt,
    input  logic [1:0]  perf_sel_i,
    output logic [31:0] perf_cnt_o
);

    logic [31:0] cnt_lu;
    logic [31:0] cnt_mdu;
    logic [31:0] cnt_fl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_lu  <= '0;
            cnt_mdu <= '0;
            cnt_fl  <= '0;
        end else begin
            if (lu_evt)  cnt_lu  <= sat_inc32(cnt_lu);
            if (mdu_evt) cnt_mdu <= sat_inc32(cnt_mdu);
            if (fl_evt)  cnt_fl  <= sat_inc32(cnt_fl);
        end
    end

    always_comb begin
        perf_cnt_o = '0;
        case (perf_sel_i)
            PERF_SEL_LU:  perf_cnt_o = cnt_lu;
            PERF_SEL_MDU: perf_cnt_o = cnt_mdu;
            PERF_SEL_FL:  perf_cnt_o = cnt_fl;
            default:      perf_cnt_o = '0;
        endcase
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard/stall sequencer: load-use interlock, MDU wait with timeout,
// redirect flush. Optional perf counters under HAZARD_PERF_CNT_EN.
//
// state        | meaning
// HZ_RUN       | normal issue; resolves redirect > MDU start > load-use
// HZ_MDU_WAIT  | pipeline frozen until mdu_done_i or timeout
// HZ_FLUSH     | squashing wrong-path instructions after a redirect
module hazard_controller
    import core::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MDU_TIMEOUT  = 64,
    parameter int REG_AW       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_rf_wr_en_i,
    input  logic              ex_is_load_i,
    input  logic              ex_mdu_start_i,
    input  logic              mdu_done_i,
    input  logic              redirect_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              stall_ex_o,
    output logic              bubble_ex_o,
    output logic              flush_if_id_o,
    output logic              mdu_timeout_o,
    output logic [1:0]        state_o,
    input  logic [1:0]        perf_sel_i,
    output logic [31:0]       perf_cnt_o
);

    localparam int WAIT_W = $clog2(MDU_TIMEOUT + 1);
    localparam int FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FL_W-1:0]   FL_RELOAD = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_TC   = WAIT_W'(MDU_TIMEOUT);

    hazard_state_t     state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [FL_W-1:0]   flush_cnt, flush_nxt;
    hazard_cntrl_t     cntrl;
    logic              timeout;
    logic              lu_evt;
    logic              load_use;

    assign load_use = ex_is_load_i & ex_rf_wr_en_i & (ex_rd_i != '0) &
                      ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                       (id_rs2_used_i & (id_rs2_i == ex_rd_i)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HZ_RUN;
            wait_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        flush_nxt = flush_cnt;
        cntrl     = '0;
        timeout   = 1'b0;
        lu_evt    = 1'b0;
        case (state)
            HZ_RUN: begin
                if (redirect_i) begin
                    cntrl.flush_if_id = 1'b1;
                    cntrl.bubble_ex   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_nxt = FL_RELOAD;
                        state_nxt = HZ_FLUSH;
                    end
                end else if (ex_mdu_start_i) begin
                    // A same-cycle done means the result is already there.
                    if (!mdu_done_i) begin
                        cntrl.stall_if = 1'b1;
                        cntrl.stall_id = 1'b1;
                        cntrl.stall_ex = 1'b1;
                        wait_nxt       = WAIT_W'(1);
                        state_nxt      = HZ_MDU_WAIT;
                    end
                end else if (load_use) begin
                    cntrl.stall_if  = 1'b1;
                    cntrl.stall_id  = 1'b1;
                    cntrl.bubble_ex = 1'b1;
                    lu_evt          = 1'b1;
                end
            end
            HZ_MDU_WAIT: begin
                if (mdu_done_i) begin
                    state_nxt = HZ_RUN;
                end else if (wait_cnt == WAIT_TC) begin
                    timeout   = 1'b1;
                    state_nxt = HZ_RUN;
                end else begin
                    cntrl.stall_if = 1'b1;
                    cntrl.stall_id = 1'b1;
                    cntrl.stall_ex = 1'b1;
                    wait_nxt       = wait_cnt + WAIT_W'(1);
                end
            end
            HZ_FLUSH: begin
                cntrl.flush_if_id = 1'b1;
                cntrl.bubble_ex   = 1'b1;
                if (redirect_i) begin
                    flush_nxt = FL_RELOAD;
                end else if (flush_cnt == FL_W'(1)) begin
                    state_nxt = HZ_RUN;
                end else begin
                    flush_nxt = flush_cnt - FL_W'(1);
                end
            end
            default: state_nxt = HZ_RUN;
        endcase
    end

    // Outputs are combinational, so they are forced low while reset is held.
    assign stall_if_o    = ~rst & cntrl.stall_if;
    assign stall_id_o    = ~rst & cntrl.stall_id;
    assign stall_ex_o    = ~rst & cntrl.stall_ex;
    assign bubble_ex_o   = ~rst & cntrl.bubble_ex;
    assign flush_if_id_o = ~rst & cntrl.flush_if_id;
    assign mdu_timeout_o = ~rst & timeout;
    assign state_o       = state;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters u_perf (
        .clk        (clk),
        .rst        (rst),
        .lu_evt     (lu_evt),
        .mdu_evt    (state == HZ_MDU_WAIT),
        .fl_evt     (flush_if_id_o),
        .perf_sel_i (perf_sel_i),
        .perf_cnt_o (perf_cnt_o)
    );
`else
    logic unused_perf;
    assign unused_perf = ^{perf_sel_i, lu_evt};
    assign perf_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (FLUSH_CYCLES=2, MDU_TIMEOUT=64).
module tb_hazard_controller;
    import core::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_rs1_used = 0, id_rs2_used = 0;
    logic        ex_rf_wr_en = 0, ex_is_load = 0, ex_mdu_start = 0;
    logic        mdu_done = 0, redirect = 0;
    logic        stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, mdu_timeout;
    logic [1:0]  state, perf_sel = '0;
    logic [31:0] perf_cnt;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    hazard_controller #(.FLUSH_CYCLES(2), .MDU_TIMEOUT(64), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_rf_wr_en_i(ex_rf_wr_en), .ex_is_load_i(ex_is_load),
        .ex_mdu_start_i(ex_mdu_start), .mdu_done_i(mdu_done), .redirect_i(redirect),
        .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
        .bubble_ex_o(bubble_ex), .flush_if_id_o(flush_if_id),
        .mdu_timeout_o(mdu_timeout), .state_o(state),
        .perf_sel_i(perf_sel), .perf_cnt_o(perf_cnt)
    );

    // ctl bit order: {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id}
    localparam logic [4:0] CTL_NONE  = 5'b00000;
    localparam logic [4:0] CTL_LU    = 5'b11010;
    localparam logic [4:0] CTL_MDU   = 5'b11100;
    localparam logic [4:0] CTL_FLUSH = 5'b00011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Check settled outputs mid-cycle, then advance to just after the next edge.
    task automatic chk_cycle(input string tag, input logic [4:0] ctl,
                             input logic [1:0] st, input logic to);
        @(negedge clk);
        chk({tag, " ctl"}, {27'd0, stall_if, stall_id, stall_ex, bubble_ex, flush_if_id}, {27'd0, ctl});
        chk({tag, " state"}, {30'd0, state}, {30'd0, st});
        chk({tag, " timeout"}, {31'd0, mdu_timeout}, {31'd0, to});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 0; id_rs2_used = 0;
        ex_rf_wr_en = 0; ex_is_load = 0;
        ex_mdu_start = 0; mdu_done = 0; redirect = 0;
    endtask

    task automatic set_lu(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_rf_wr_en = wr; ex_is_load = ld;
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, wr, ld, stall;
    } lu_vec_t;

    lu_vec_t lu_vecs[7] = '{
        '{rs1:5, rs2:0, rd:5, u1:1, u2:0, wr:1, ld:1, stall:1},
        '{rs1:3, rs2:5, rd:5, u1:1, u2:1, wr:1, ld:1, stall:1},
        '{rs1:5, rs2:7, rd:5, u1:0, u2:1, wr:1, ld:1, stall:0},
        '{rs1:0, rs2:0, rd:0, u1:1, u2:1, wr:1, ld:1, stall:0},
        '{rs1:5, rs2:0, rd:5, u1:1, u2:0, wr:0, ld:1, stall:0},
        '{rs1:5, rs2:0, rd:5, u1:1, u2:0, wr:1, ld:0, stall:0},
        '{rs1:9, rs2:9, rd:9, u1:1, u2:1, wr:1, ld:1, stall:1}
    };

    initial begin
        logic [31:0] perf_exp[4];

        // Reset with every hazard input active: outputs must stay low.
        idle();
        redirect = 1; ex_mdu_start = 1;
        set_lu(5, 0, 1, 0, 5, 1, 1);
        @(posedge clk); #1;
        chk("rst ctl", {27'd0, stall_if, stall_id, stall_ex, bubble_ex, flush_if_id}, 32'd0);
        chk("rst state", {30'd0, state}, 32'd0);
        chk("rst timeout", {31'd0, mdu_timeout}, 32'd0);
        chk("rst perf", perf_cnt, 32'd0);
        idle();
        @(posedge clk); #1;
        rst = 0;
        chk_cycle("post rst", CTL_NONE, 2'd0, 0);

        // Load-use vectors, each followed by a cycle where the bubble cleared EX.
        foreach (lu_vecs[i]) begin
            set_lu(lu_vecs[i].rs1, lu_vecs[i].rs2, lu_vecs[i].u1, lu_vecs[i].u2,
                   lu_vecs[i].rd, lu_vecs[i].wr, lu_vecs[i].ld);
            chk_cycle("load_use", lu_vecs[i].stall ? CTL_LU : CTL_NONE, 2'd0, 0);
            idle();
            chk_cycle("load_use after", CTL_NONE, 2'd0, 0);
        end

        // MDU wait: done arrives 34 cycles after start; redirect/load-use in between ignored.
        ex_mdu_start = 1;
        chk_cycle("mdu start", CTL_MDU, 2'd0, 0);
        idle();
        for (int i = 1; i <= 33; i++) begin
            if (i == 10) begin
                redirect = 1;
                set_lu(5, 0, 1, 0, 5, 1, 1);
            end
            chk_cycle("mdu wait", CTL_MDU, 2'd1, 0);
            idle();
        end
        mdu_done = 1;
        chk_cycle("mdu done", CTL_NONE, 2'd1, 0);
        idle();
        chk_cycle("mdu back", CTL_NONE, 2'd0, 0);

        // Single redirect: two flush cycles.
        redirect = 1;
        chk_cycle("redir c0", CTL_FLUSH, 2'd0, 0);
        idle();
        chk_cycle("redir c1", CTL_FLUSH, 2'd2, 0);
        chk_cycle("redir end", CTL_NONE, 2'd0, 0);

        // Perf readback: 3 load-use stalls, 34 MDU wait cycles, 2 flush cycles.
        perf_exp = '{3, 34, 2, 0};
        for (int s = 0; s < 4; s++) begin
            perf_sel = 2'(s);
            #1;
            chk("perf sel", perf_cnt, PERF_EN ? perf_exp[s] : 32'd0);
        end
        perf_sel = '0;
        @(posedge clk); #1;

        // MDU timeout after 64 wait cycles, then a stray done.
        ex_mdu_start = 1;
        chk_cycle("to start", CTL_MDU, 2'd0, 0);
        idle();
        for (int i = 1; i <= 63; i++) chk_cycle("to wait", CTL_MDU, 2'd1, 0);
        chk_cycle("to pulse", CTL_NONE, 2'd1, 1);
        mdu_done = 1;
        chk_cycle("to stray done", CTL_NONE, 2'd0, 0);
        idle();
        chk_cycle("to after", CTL_NONE, 2'd0, 0);

        // Back-to-back redirects extend the flush by one cycle.
        redirect = 1;
        chk_cycle("redir2 c0", CTL_FLUSH, 2'd0, 0);
        chk_cycle("redir2 c1", CTL_FLUSH, 2'd2, 0);
        idle();
        chk_cycle("redir2 c2", CTL_FLUSH, 2'd2, 0);
        chk_cycle("redir2 end", CTL_NONE, 2'd0, 0);

        // Priority: redirect wins over MDU start and load-use.
        redirect = 1; ex_mdu_start = 1;
        set_lu(5, 0, 1, 0, 5, 1, 1);
        chk_cycle("prio c0", CTL_FLUSH, 2'd0, 0);
        redirect = 0;
        chk_cycle("prio c1", CTL_FLUSH, 2'd2, 0);
        idle();
        chk_cycle("prio end", CTL_NONE, 2'd0, 0);

        // Reset in the middle of an MDU wait.
        ex_mdu_start = 1;
        chk_cycle("rst mdu start", CTL_MDU, 2'd0, 0);
        idle();
        chk_cycle("rst mdu wait", CTL_MDU, 2'd1, 0);
        rst = 1;
        #1;
        chk("rst mid ctl", {27'd0, stall_if, stall_id, stall_ex, bubble_ex, flush_if_id}, 32'd0);
        chk("rst mid state", {30'd0, state}, 32'd0);
        perf_sel = PERF_SEL_MDU;
        #1;
        chk("rst mid perf", perf_cnt, 32'd0);
        perf_sel = '0;
        @(posedge clk); #1;
        rst = 0;
        chk_cycle("rst mid after", CTL_NONE, 2'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
